// File: rtl/buffer_read_address_generator_if.sv
// Handshake and configuration bundle between the read address generator and its
// controller/datapath.
interface buffer_read_address_generator_if #(
    parameter int unsigned BUFFER_ADDRESS_WIDTH = 10,
    parameter int unsigned DIM_WIDTH            = 8
);
    localparam int unsigned COUNT_WIDTH = 16;

    logic                            start_i;
    logic [DIM_WIDTH-1:0]            rows_i;
    logic [DIM_WIDTH-1:0]            cols_i;
    logic [DIM_WIDTH-1:0]            repeat_i;
    logic [COUNT_WIDTH-1:0]          write_count_i;
    logic                            addr_ready_i;
    logic                            addr_valid_o;
    logic [BUFFER_ADDRESS_WIDTH-1:0] address_o;
    logic                            last_o;
    logic                            done_o;
    logic                            busy_o;

    modport master (
        output start_i, rows_i, cols_i, repeat_i, write_count_i, addr_ready_i,
        input  addr_valid_o, address_o, last_o, done_o, busy_o
    );

    modport slave (
        input  start_i, rows_i, cols_i, repeat_i, write_count_i, addr_ready_i,
        output addr_valid_o, address_o, last_o, done_o, busy_o
    );
endinterface

// File: rtl/buffer_read_address_generator.sv
// Walks a row-major operand matrix, replaying each row once per output column,
// and stalls on entries the writer has not produced yet.
module buffer_read_address_generator #(
    parameter int unsigned BUFFER_ADDRESS_WIDTH = 10,
    parameter int unsigned DIM_WIDTH            = 8
) (
    input  logic clk,
    input  logic reset_n,
    buffer_read_address_generator_if.slave bus
);
    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [DIM_WIDTH-1:0]   rows_q;
    logic [DIM_WIDTH-1:0]   cols_q;
    logic [DIM_WIDTH-1:0]   repeat_q;
    logic [DIM_WIDTH-1:0]   col_cnt;
    logic [DIM_WIDTH-1:0]   rep_cnt;
    logic [DIM_WIDTH-1:0]   row_cnt;
    logic [COUNT_WIDTH-1:0] row_base;
    logic                   done_q;
    logic                   busy_q;

    logic [COUNT_WIDTH-1:0] lin_c;
    logic                   addr_valid_c;
    logic                   fire_c;
    logic                   col_last_c;
    logic                   rep_last_c;
    logic                   row_last_c;
    logic                   dims_ok_c;

    // Position decode; valid gates on the writer having produced this entry.
    always_comb begin
        lin_c        = row_base + COUNT_WIDTH'(col_cnt);
        col_last_c   = (col_cnt == cols_q - DIM_WIDTH'(1));
        rep_last_c   = (rep_cnt == repeat_q - DIM_WIDTH'(1));
        row_last_c   = (row_cnt == rows_q - DIM_WIDTH'(1));
        addr_valid_c = (state == RUN) && (lin_c < bus.write_count_i);
        fire_c       = addr_valid_c && bus.addr_ready_i;
        dims_ok_c    = (bus.rows_i != '0) && (bus.cols_i != '0) && (bus.repeat_i != '0);
    end

    assign bus.addr_valid_o = addr_valid_c;
    assign bus.address_o    = lin_c[BUFFER_ADDRESS_WIDTH-1:0];
    assign bus.last_o       = addr_valid_c && col_last_c;
    assign bus.done_o       = done_q;
    assign bus.busy_o       = busy_q;

    // Control FSM and walk counters; counters advance only on an accepted address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rows_q   <= '0;
            cols_q   <= '0;
            repeat_q <= '0;
            col_cnt  <= '0;
            rep_cnt  <= '0;
            row_cnt  <= '0;
            row_base <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        busy_q <= 1'b1;
                        if (dims_ok_c) begin
                            state    <= RUN;
                            rows_q   <= bus.rows_i;
                            cols_q   <= bus.cols_i;
                            repeat_q <= bus.repeat_i;
                            col_cnt  <= '0;
                            rep_cnt  <= '0;
                            row_cnt  <= '0;
                            row_base <= '0;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire_c) begin
                        if (col_last_c) begin
                            col_cnt <= '0;
                            if (rep_last_c) begin
                                rep_cnt  <= '0;
                                row_cnt  <= row_cnt + DIM_WIDTH'(1);
                                row_base <= row_base + COUNT_WIDTH'(cols_q);
                                if (row_last_c) begin
                                    state  <= DONE;
                                    done_q <= 1'b1;
                                end
                            end else begin
                                rep_cnt <= rep_cnt + DIM_WIDTH'(1);
                            end
                        end else begin
                            col_cnt <= col_cnt + DIM_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_buffer_read_address_generator.sv
// Directed bench for buffer_read_address_generator: sequence, stall,
// backpressure, zero-dimension, wrap and mid-run reset.
module tb_buffer_read_address_generator;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    buffer_read_address_generator_if #(.BUFFER_ADDRESS_WIDTH(10), .DIM_WIDTH(8)) b1 ();
    buffer_read_address_generator_if #(.BUFFER_ADDRESS_WIDTH(4),  .DIM_WIDTH(8)) b2 ();

    buffer_read_address_generator #(.BUFFER_ADDRESS_WIDTH(10), .DIM_WIDTH(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(b1)
    );
    buffer_read_address_generator #(.BUFFER_ADDRESS_WIDTH(4), .DIM_WIDTH(8)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .bus(b2)
    );

    int checks = 0;
    int errors = 0;
    int steps  = 0;
    int f1_addr[$], f1_last[$], f1_step[$];
    int f2_addr[$], f2_last[$];
    logic s_valid, s_last, s_done, s_busy, s2_done;
    int   s_addr;

    int exp1[12]  = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int expl1[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already set; samples, logs fires, advances one cycle.
    task automatic step();
        #1;
        s_valid = b1.addr_valid_o;
        s_addr  = int'(b1.address_o);
        s_last  = b1.last_o;
        s_done  = b1.done_o;
        s_busy  = b1.busy_o;
        s2_done = b2.done_o;
        if (b1.addr_valid_o && b1.addr_ready_i) begin
            f1_addr.push_back(int'(b1.address_o));
            f1_last.push_back(int'(b1.last_o));
            f1_step.push_back(steps);
        end
        if (b2.addr_valid_o && b2.addr_ready_i) begin
            f2_addr.push_back(int'(b2.address_o));
            f2_last.push_back(int'(b2.last_o));
        end
        steps++;
        @(negedge clk);
    endtask

    task automatic clear_log();
        f1_addr.delete(); f1_last.delete(); f1_step.delete();
        f2_addr.delete(); f2_last.delete();
    endtask

    task automatic start_pass(input int r, input int c, input int rp);
        b1.rows_i   = 8'(r);
        b1.cols_i   = 8'(c);
        b1.repeat_i = 8'(rp);
        b1.start_i  = 1'b1;
        step();
        b1.start_i  = 1'b0;
    endtask

    task automatic run_to_done(input string tag, output int done_step);
        done_step = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (s_done) begin
                done_step = steps - 1;
                break;
            end
        end
        check({tag, "_done_seen"}, int'(s_done), 1);
    endtask

    task automatic check_seq1(input string tag);
        check({tag, "_nfires"}, f1_addr.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < f1_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), f1_addr[i], exp1[i]);
                check($sformatf("%s_last%0d", tag, i), f1_last[i], expl1[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ds;
        int nf;
        logic exp_v;

        reset_n = 1'b0;
        b1.start_i = 0; b1.rows_i = 0; b1.cols_i = 0; b1.repeat_i = 0;
        b1.write_count_i = 0; b1.addr_ready_i = 0;
        b2.start_i = 0; b2.rows_i = 0; b2.cols_i = 0; b2.repeat_i = 0;
        b2.write_count_i = 0; b2.addr_ready_i = 0;
        @(negedge clk);
        step();
        check("rst_valid", int'(s_valid), 0);
        check("rst_addr",  s_addr, 0);
        check("rst_last",  int'(s_last), 0);
        check("rst_done",  int'(s_done), 0);
        check("rst_busy",  int'(s_busy), 0);
        reset_n = 1'b1;
        step();

        // Basic sequence with all data present
        clear_log();
        b1.write_count_i = 16'd6;
        b1.addr_ready_i  = 1'b1;
        start_pass(2, 3, 2);
        run_to_done("t1", ds);
        check("t1_busy_in_done", int'(s_busy), 1);
        check_seq1("t1");
        if (f1_step.size() > 0)
            check("t1_done_latency", ds, f1_step[f1_step.size()-1] + 1);
        step();
        check("t1_done_pulse", int'(s_done), 0);
        check("t1_busy_idle",  int'(s_busy), 0);

        // Data stall: writer count creeps up by one every 3 cycles
        clear_log();
        b1.write_count_i = 16'd1;
        start_pass(2, 3, 2);
        nf = 0;
        for (int k = 0; k < 300; k++) begin
            if (k > 0 && k % 3 == 0) b1.write_count_i = b1.write_count_i + 16'd1;
            exp_v = (nf < 12) && (exp1[nf] < int'(b1.write_count_i));
            step();
            check($sformatf("t2_valid_k%0d", k), int'(s_valid), int'(exp_v));
            if (exp_v) begin
                check($sformatf("t2_addr_k%0d", k), s_addr, exp1[nf]);
                nf++;
            end
            if (s_done) break;
        end
        check("t2_done_seen", int'(s_done), 1);
        check_seq1("t2");
        step();

        // Backpressure at address 2
        clear_log();
        b1.write_count_i = 16'd6;
        start_pass(2, 3, 2);
        step();
        step();
        b1.addr_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t3_hold_valid%0d", k), int'(s_valid), 1);
            check($sformatf("t3_hold_addr%0d", k),  s_addr, 2);
            check($sformatf("t3_hold_last%0d", k),  int'(s_last), 1);
        end
        b1.addr_ready_i = 1'b1;
        step();
        check("t3_release_addr", s_addr, 2);
        step();
        check("t3_next_addr", s_addr, 0);
        run_to_done("t3", ds);
        check_seq1("t3");
        step();

        // Zero dimension, then start ignored while running
        clear_log();
        start_pass(2, 0, 2);
        check("t4_busy_at_start", int'(s_busy), 0);
        step();
        check("t4_zero_done",  int'(s_done), 1);
        check("t4_zero_busy",  int'(s_busy), 1);
        check("t4_zero_valid", int'(s_valid), 0);
        step();
        check("t4_zero_done_clr", int'(s_done), 0);
        check("t4_zero_busy_clr", int'(s_busy), 0);
        check("t4_zero_nfires", f1_addr.size(), 0);
        b1.write_count_i = 16'd0;
        start_pass(2, 3, 2);
        step();
        check("t4_stall_valid", int'(s_valid), 0);
        check("t4_stall_busy",  int'(s_busy), 1);
        b1.rows_i = 8'd1; b1.cols_i = 8'd1; b1.repeat_i = 8'd1;
        b1.start_i = 1'b1;
        step();
        b1.start_i = 1'b0;
        step();
        check("t4_run_busy", int'(s_busy), 1);
        check("t4_run_done", int'(s_done), 0);
        b1.write_count_i = 16'd6;
        run_to_done("t4", ds);
        check_seq1("t4");
        step();

        // Address wrap on the 4-bit instance
        clear_log();
        b2.write_count_i = 16'd24;
        b2.addr_ready_i  = 1'b1;
        b2.rows_i = 8'd3; b2.cols_i = 8'd8; b2.repeat_i = 8'd1;
        b2.start_i = 1'b1;
        step();
        b2.start_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (s2_done) break;
        end
        check("t5_done_seen", int'(s2_done), 1);
        check("t5_nfires", f2_addr.size(), 24);
        for (int i = 0; i < 24; i++) begin
            if (i < f2_addr.size()) begin
                check($sformatf("t5_addr%0d", i), f2_addr[i], (i < 16) ? i : i - 16);
                check($sformatf("t5_last%0d", i), f2_last[i], (i % 8 == 7) ? 1 : 0);
            end
        end
        step();

        // Asynchronous reset in the middle of a run
        clear_log();
        b1.write_count_i = 16'd6;
        start_pass(2, 3, 2);
        step();
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(b1.addr_valid_o), 0);
        check("t6_rst_addr",  int'(b1.address_o), 0);
        check("t6_rst_last",  int'(b1.last_o), 0);
        check("t6_rst_done",  int'(b1.done_o), 0);
        check("t6_rst_busy",  int'(b1.busy_o), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t6_no_done%0d", k), int'(s_done), 0);
        end
        clear_log();
        start_pass(2, 3, 2);
        step();
        check("t6_restart_nfires", f1_addr.size(), 1);
        if (f1_addr.size() > 0)
            check("t6_restart_addr", f1_addr[0], 0);
        run_to_done("t6", ds);
        check_seq1("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
